// File: rtl/alu_iterative.sv
// Area-lean RISC-V ALU: single-cycle arithmetic/logic/compare, bit-serial shifts.
// Valid/ready handshakes on both sides let the control unit stall during a shift.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shop_e;

  state_e           state_q,     state_d;
  shop_e            shop_q,      shop_d;
  logic [SHW-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             illegal_q,   illegal_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SHW-1:0]   shamt;
  logic             is_shift;
  shop_e            shop_new;

  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    shop_d    = shop_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    is_shift  = 1'b0;
    shop_new  = SH_SLL;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          illegal_d = 1'b0;
          state_d   = S_DONE;
          case (ALUControl)
            OP_ADD:  result_d = SrcA + SrcB;
            OP_SUB:  result_d = SrcA - SrcB;
            OP_AND:  result_d = SrcA & SrcB;
            OP_OR:   result_d = SrcA | SrcB;
            OP_XOR:  result_d = SrcA ^ SrcB;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            OP_SLL: begin is_shift = 1'b1; shop_new = SH_SLL; end
            OP_SRL: begin is_shift = 1'b1; shop_new = SH_SRL; end
            OP_SRA: begin is_shift = 1'b1; shop_new = SH_SRA; end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
          // The working register doubles as the result register during a shift.
          if (is_shift) begin
            result_d = SrcA;
            shop_d   = shop_new;
            cnt_d    = shamt;
            if (shamt != '0) state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        unique case (shop_q)
          SH_SLL:  result_d = {result_q[WIDTH-2:0], 1'b0};
          SH_SRL:  result_d = {1'b0, result_q[WIDTH-1:1]};
          default: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        endcase
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) state_d = S_DONE;
      end

      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      shop_q      <= SH_SLL;
      cnt_q       <= '0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shop_q      <= shop_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = (result_q == '0);
  assign illegal   = illegal_q;

endmodule
